lcd_result_writer: RTL and testbench
====================================

LCD_RESULT_WRITER -- requirements
Module: lcd_result_writer

Interface
REQ-001 SHALL have parameter INIT_WAIT, default 750000, giving power-on wait cycles before the first LCD command.
REQ-002 SHALL have parameter EN_PULSE, default 12, giving lcd_en high time in cycles.
REQ-003 SHALL have parameter CMD_WAIT, default 2500, giving the post-pulse wait in cycles for every byte except clear.
REQ-004 SHALL have parameter CLR_WAIT, default 82000, giving the post-pulse wait in cycles after the clear command 0x01.
REQ-005 clk  input  1  single system clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 result_i  input  16  unsigned result from the exponent datapath.
REQ-008 ld_output  input  1  result-valid strobe; result_i is valid in any cycle ld_output=1.
REQ-009 lcd_data  output  8  LCD DB7..DB0.
REQ-010 lcd_rs  output  1  0=command, 1=character data.
REQ-011 lcd_rw  output  1  constant 0 (write only).
REQ-012 lcd_en  output  1  LCD enable strobe.
REQ-013 busy  output  1  1 whenever state is not IDLE.
REQ-014 wr_done  output  1  one-cycle pulse when a full result has been written.

Function
REQ-015 States SHALL be PWR_WAIT, INIT, IDLE, CONVERT, SEND_ADDR, SEND_DIGIT, DONE; byte transfers SHALL use sub-phases SETUP, EN_HI, WAIT.
REQ-016 Each byte transfer SHALL be: 1 SETUP cycle (lcd_en=0, lcd_data/lcd_rs valid), EN_PULSE cycles with lcd_en=1, then CMD_WAIT (CLR_WAIT for 0x01) cycles with lcd_en=0; lcd_data/lcd_rs SHALL be stable throughout the transfer.
REQ-017 PWR_WAIT SHALL count INIT_WAIT cycles, then go to INIT.
REQ-018 INIT SHALL send commands 0x38, 0x0C, 0x06, 0x01 in order (lcd_rs=0), then go to IDLE.
REQ-019 In IDLE, ld_output=1 SHALL capture result_i and go to CONVERT in the same edge.
REQ-020 CONVERT SHALL run double-dabble binary-to-BCD for exactly 16 cycles, producing 5 digits (ten-thousands to units).
REQ-021 SEND_ADDR SHALL send command 0x80 (lcd_rs=0); SEND_DIGIT SHALL then send 5 characters (lcd_rs=1), most significant first.
REQ-022 Character byte SHALL be 0x30+digit, except leading zeros SHALL be 0x20 (space); the units digit SHALL always be printed.
REQ-023 The first lcd_en rise of SEND_ADDR SHALL occur 17 edges after the edge that sampled ld_output.
REQ-024 DONE SHALL last one cycle with wr_done=1, then go to IDLE (or CONVERT per REQ-026).
REQ-025 ld_output=1 while not IDLE and not PWR_WAIT/INIT SHALL load a one-deep pending register with result_i; a later strobe SHALL overwrite it (last value wins).
REQ-026 On leaving DONE with pending set, the block SHALL capture the pending value, clear pending, and enter CONVERT directly without passing through IDLE.
REQ-027 ld_output during PWR_WAIT or INIT SHALL be ignored.
REQ-028 ld_output in the DONE cycle SHALL be treated as pending (REQ-025).
REQ-029 All counters SHALL be wide enough for the largest parameter; no wrap-around within a wait.

Reset
REQ-030 With rst=0 at a clock edge: state=PWR_WAIT, counters=0, pending cleared, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, busy=1, wr_done=0.
REQ-031 Reset asserted mid-transfer SHALL force lcd_en=0 at that edge and restart the full power-on sequence.

Verification (INIT_WAIT=20, EN_PULSE=2, CMD_WAIT=4, CLR_WAIT=10)
REQ-032 Reset release, no strobes -> 20 idle cycles, then enables carry 0x38, 0x0C, 0x06, 0x01 with rs=0, each en high exactly 2 cycles; busy falls 10 cycles after the 0x01 en falls.
REQ-033 IDLE, result_i=256, ld_output pulse -> en rises 17 edges later with 0x80, then rs=1 bytes 0x20,0x20,0x32,0x35,0x36; wr_done pulses once.
REQ-034 result_i=0 -> bytes 0x20,0x20,0x20,0x20,0x30; result_i=65535 -> 0x36,0x35,0x35,0x33,0x35.
REQ-035 Strobe 81 then 9 and 1024 during busy -> first write "   81", then immediately "1024" with leading space (0x20,0x31,0x30,0x32,0x34) with no IDLE cycle between; 9 never displayed.
REQ-036 Strobe during PWR_WAIT -> no extra write after init; rst=0 during a character's en-high cycle -> en=0 on that edge and 20-cycle power wait restarts.

Source files
------------

// File: rtl/lcd_result_writer.sv
// lcd_result_writer
// Brings up an HD44780-style character LCD in 8-bit mode, then waits for
// results from the exponent datapath. Each result is converted to five BCD
// digits and written at DDRAM address 0x00, with leading zeros shown as spaces.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active low
//   result_i   16-bit unsigned result, valid whenever ld_output=1
//   ld_output  result-valid strobe
//   lcd_data   LCD DB7..DB0
//   lcd_rs     0 = command, 1 = character data
//   lcd_rw     tied to 0, the panel is only written
//   lcd_en     LCD enable strobe
//   busy       high in every state except IDLE
//   wr_done    one-cycle pulse after the last character of a result
//
// state       | meaning
// ------------+------------------------------------------------------
// PWR_WAIT    | power-on delay before the panel accepts commands
// INIT        | function set, display on, entry mode, clear
// IDLE        | waiting for a result strobe
// CONVERT     | 16 double-dabble steps, binary to five BCD digits
// SEND_ADDR   | set DDRAM address 0x80
// SEND_DIGIT  | five characters, most significant first
// DONE        | wr_done pulse; a pending result restarts CONVERT
module lcd_result_writer #(
    parameter int INIT_WAIT = 750000,
    parameter int EN_PULSE  = 12,
    parameter int CMD_WAIT  = 2500,
    parameter int CLR_WAIT  = 82000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result_i,
    input  logic        ld_output,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        busy,
    output logic        wr_done
);
    // One shared counter serves every wait and the 16 conversion steps,
    // so it is sized for the largest of all of them.
    localparam int MAX_A   = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int MAX_B   = (CMD_WAIT > EN_PULSE) ? CMD_WAIT : EN_PULSE;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_ALL = (MAX_C > 16) ? MAX_C : 16;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] EN_LAST   = CW'(EN_PULSE - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(15);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, CONVERT, SEND_ADDR, SEND_DIGIT, DONE
    } state_t;

    typedef enum logic [1:0] {SETUP, EN_HI, WAIT} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   bin_q, bin_d;
    logic [19:0]   bcd_q, bcd_d;
    logic          pend_q, pend_d;
    logic [15:0]   pend_val_q, pend_val_d;

    logic          xfer;
    logic          byte_done;
    logic [CW-1:0] wait_last;
    logic [7:0]    cur_byte;
    logic [3:0]    digit;
    logic          lead_zero;
    logic [19:0]   bcd_adj;

    function automatic logic [19:0] dd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= PWR_WAIT;
            phase_q    <= SETUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

    // Leading-zero blanking looks at this digit and every digit above it;
    // the units digit is never blanked.
    always_comb begin
        digit     = bcd_q[3:0];
        lead_zero = 1'b0;
        case (idx_q)
            3'd0: begin digit = bcd_q[19:16]; lead_zero = (bcd_q[19:16] == '0); end
            3'd1: begin digit = bcd_q[15:12]; lead_zero = (bcd_q[19:12] == '0); end
            3'd2: begin digit = bcd_q[11:8];  lead_zero = (bcd_q[19:8]  == '0); end
            3'd3: begin digit = bcd_q[7:4];   lead_zero = (bcd_q[19:4]  == '0); end
            default: ;
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            INIT: begin
                case (idx_q)
                    3'd0:    cur_byte = 8'h38;
                    3'd1:    cur_byte = 8'h0C;
                    3'd2:    cur_byte = 8'h06;
                    default: cur_byte = 8'h01;
                endcase
            end
            SEND_ADDR:  cur_byte = 8'h80;
            SEND_DIGIT: cur_byte = lead_zero ? 8'h20 : {4'h3, digit};
            default: ;
        endcase
    end

    assign xfer      = (state_q == INIT) || (state_q == SEND_ADDR) || (state_q == SEND_DIGIT);
    assign wait_last = (state_q == INIT && idx_q == 3'd3) ? CLR_LAST : CMD_LAST;
    assign bcd_adj   = dd_adjust(bcd_q);

    // Byte and rs come straight from state/index, which are frozen for the
    // whole transfer, so the bus cannot move while the panel is latching it.
    assign lcd_data = xfer ? cur_byte : 8'h00;
    assign lcd_rs   = (state_q == SEND_DIGIT);
    assign lcd_rw   = 1'b0;
    assign lcd_en   = xfer && (phase_q == EN_HI);
    assign busy     = (state_q != IDLE);
    assign wr_done  = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        byte_done  = 1'b0;

        if (xfer) begin
            case (phase_q)
                SETUP: begin
                    phase_d = EN_HI;
                    cnt_d   = '0;
                end
                EN_HI: begin
                    if (cnt_q == EN_LAST) begin
                        phase_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == wait_last) begin
                        byte_done = 1'b1;
                        phase_d   = SETUP;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // Strobes while a result is in flight park in a one-deep slot.
        if (ld_output && (state_q == CONVERT || state_q == SEND_ADDR || state_q == SEND_DIGIT)) begin
            pend_d     = 1'b1;
            pend_val_d = result_i;
        end

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = INIT;
                    phase_d = SETUP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT: begin
                if (byte_done) begin
                    if (idx_q == 3'd3) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            IDLE: begin
                if (ld_output) begin
                    state_d = CONVERT;
                    bin_d   = result_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                bcd_d = {bcd_adj[18:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                if (cnt_q == CONV_LAST) begin
                    state_d = SEND_ADDR;
                    phase_d = SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND_ADDR: begin
                if (byte_done) begin
                    state_d = SEND_DIGIT;
                    idx_d   = '0;
                end
            end
            SEND_DIGIT: begin
                if (byte_done) begin
                    if (idx_q == 3'd4) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                // A strobe in the DONE cycle itself is the newest value and wins.
                if (pend_q || ld_output) begin
                    state_d = CONVERT;
                    bin_d   = ld_output ? result_i : pend_val_q;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_lcd_result_writer.sv
module tb_lcd_result_writer;
    localparam int INIT_WAIT = 20;
    localparam int EN_PULSE  = 2;
    localparam int CMD_WAIT  = 4;
    localparam int CLR_WAIT  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] result_i;
    logic        ld_output;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        busy;
    logic        wr_done;

    lcd_result_writer #(
        .INIT_WAIT(INIT_WAIT),
        .EN_PULSE (EN_PULSE),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .result_i (result_i),
        .ld_output(ld_output),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .busy     (busy),
        .wr_done  (wr_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int ld_cyc = 0;
    int fall_cyc = 0;
    int done_cnt = 0;

    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference formatter: five characters, spaces for leading zeros,
    // units digit always shown.
    function automatic logic [39:0] fmt5(input int v);
        logic [39:0] r;
        bit lead;
        int d;
        r = '0;
        lead = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            d = (v / (10 ** i)) % 10;
            r = r << 8;
            if (lead && d == 0 && i != 0) begin
                r[7:0] = 8'h20;
            end else begin
                lead = 1'b0;
                r[7:0] = 8'h30 + 8'(d);
            end
        end
        return r;
    endfunction

    task automatic push_result(input int v);
        logic [39:0] r;
        r = fmt5(v);
        exp_q.push_back(9'h080);
        for (int i = 4; i >= 0; i--) exp_q.push_back({1'b1, r[8*i +: 8]});
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) rst_cyc = cyc;
        if (ld_output) ld_cyc = cyc;
    end

    // Bus monitor: every enable pulse must carry the next expected byte,
    // be EN_PULSE cycles wide, and keep the byte steady through its wait.
    logic       en_prev = 1'b0;
    logic [8:0] cur_byte = '0;
    int         hi_len = 0;
    int         post_left = 0;

    always @(negedge clk) begin
        if (cyc == rst_cyc) begin
            en_prev   = 1'b0;
            hi_len    = 0;
            post_left = 0;
        end else begin
            if (lcd_en && !en_prev) begin
                cur_byte  = {lcd_rs, lcd_data};
                hi_len    = 1;
                post_left = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", cur_byte, cyc);
                end else begin
                    chk("byte", cur_byte, exp_q.pop_front());
                end
                chk("rw_low", lcd_rw, 1'b0);
            end else if (lcd_en) begin
                hi_len++;
                chk("stable_en_hi", {lcd_rs, lcd_data}, cur_byte);
            end else if (en_prev) begin
                chk("en_width", hi_len, EN_PULSE);
                fall_cyc  = cyc;
                post_left = (cur_byte == 9'h001) ? CLR_WAIT : CMD_WAIT;
            end
            if (!lcd_en && post_left > 0) begin
                chk("stable_wait", {lcd_rs, lcd_data}, cur_byte);
                post_left--;
            end
            if (wr_done) done_cnt++;
            en_prev = lcd_en;
        end
    end

    task automatic strobe(input logic [15:0] v);
        result_i  = v;
        ld_output = 1'b1;
        @(negedge clk);
        ld_output = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic wait_en(input bit need_rs, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(lcd_en && (!need_rs || lcd_rs)) && n < budget);
        chk("en_seen", lcd_en, 1'b1);
    endtask

    int base;
    int idle_seen;
    int dones;
    int n;
    int vals[2] = '{0, 65535};

    initial begin
        rst       = 1'b0;
        ld_output = 1'b0;
        result_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_en", lcd_en, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_wr_done", wr_done, 1'b0);

        // Power-up, with a strobe during the power wait that must be dropped.
        push_init();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        strobe(16'd1234);
        wait_en(1'b0, 100);
        chk("init_first_en_delay", cyc - rst_cyc, INIT_WAIT + 1);
        wait_idle(300);
        chk("busy_fall_after_clear", cyc - fall_cyc, CLR_WAIT);
        repeat (30) @(negedge clk);
        chk("init_queue_empty", exp_q.size(), 0);
        chk("no_write_after_init", done_cnt, 0);
        chk("still_idle", busy, 1'b0);

        // Hand-computed character strings that pin the formatter.
        chk("model_256", fmt5(256), 40'h2020323536);
        chk("model_0", fmt5(0), 40'h2020202030);
        chk("model_65535", fmt5(65535), 40'h3635353335);
        chk("model_1024", fmt5(1024), 40'h2031303234);
        chk("model_81", fmt5(81), 40'h2020203831);

        // Single result, with the address-strobe latency.
        base = done_cnt;
        push_result(256);
        strobe(16'd256);
        wait_en(1'b0, 100);
        chk("addr_en_latency", cyc - ld_cyc, 17);
        chk("addr_byte", {lcd_rs, lcd_data}, 9'h080);
        wait_idle(400);
        chk("q_empty_256", exp_q.size(), 0);
        chk("wr_done_once_256", done_cnt - base, 1);

        foreach (vals[k]) begin
            base = done_cnt;
            push_result(vals[k]);
            strobe(vals[k][15:0]);
            wait_idle(400);
            chk("q_empty_edge_value", exp_q.size(), 0);
            chk("wr_done_once_edge_value", done_cnt - base, 1);
        end

        // Back-to-back: 81, then 9 and 1024 while busy; 1024 overwrites 9.
        base = done_cnt;
        push_result(81);
        push_result(1024);
        strobe(16'd81);
        idle_seen = 0;
        dones = 0;
        n = 0;
        while (dones < 2 && n < 600) begin
            if (n == 4) begin
                result_i = 16'd9;
                ld_output = 1'b1;
            end else if (n == 40) begin
                result_i = 16'd1024;
                ld_output = 1'b1;
            end else begin
                ld_output = 1'b0;
            end
            @(negedge clk);
            n++;
            if (!busy) idle_seen++;
            if (wr_done) dones++;
        end
        ld_output = 1'b0;
        chk("no_idle_between_writes", idle_seen, 0);
        wait_idle(100);
        chk("two_writes", done_cnt - base, 2);
        chk("q_empty_pending", exp_q.size(), 0);

        // Reset while the first character's enable is high.
        base = done_cnt;
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h131);
        strobe(16'd12345);
        wait_en(1'b1, 200);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_en", lcd_en, 1'b0);
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_data", lcd_data, 8'h00);
        chk("midrst_wr_done", wr_done, 1'b0);
        exp_q.delete();
        push_init();
        rst = 1'b1;
        wait_en(1'b0, 100);
        chk("reinit_first_en_delay", cyc - rst_cyc, INIT_WAIT + 1);
        wait_idle(300);
        chk("reinit_queue_empty", exp_q.size(), 0);
        chk("no_done_after_abort", done_cnt - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
